// File: rtl/pipe_pkg.sv
// Shared pipeline constants: write-back source selects, load funct3 codes and a byte-lane helper.
package pipe_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/load_align.sv
// Formats the raw aligned memory word into the register value for each load type.
module load_align
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = pick_byte(mem_rdata[31:0], addr_lo);
    // Halfword loads are naturally aligned, so only addr_lo[1] picks the half.
    assign half_s = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Sign/zero extension per load type; unknown codes fall back to a full word.
    always_comb begin
        load_data = mem_rdata;
        case (load_funct3)
            LD_LB:   load_data = {{(XLEN-8){byte_s[7]}}, byte_s};
            LD_LH:   load_data = {{(XLEN-16){half_s[15]}}, half_s};
            LD_LW:   load_data = mem_rdata;
            LD_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_s};
            LD_LHU:  load_data = {{(XLEN-16){1'b0}}, half_s};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, guards x0 and counts retired instructions.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [4:0]      rd_in,
    input  logic            reg_write_in,
    input  logic [1:0]      wb_sel,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] write_data,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            wb_valid,
    output logic [31:0]     retire_count
);

    logic [XLEN-1:0] load_data_s;
    logic [XLEN-1:0] sel_data_s;
    logic            write_en_s;

    logic [XLEN-1:0] write_data_r;
    logic [4:0]      rd_r;
    logic            reg_write_r;
    logic            wb_valid_r;
    logic [31:0]     retire_count_r;

    load_align #(.XLEN(XLEN)) u_load_align (
        .mem_rdata   (mem_rdata),
        .load_funct3 (load_funct3),
        .addr_lo     (addr_lo),
        .load_data   (load_data_s)
    );

    // Write-back source mux; the unused encoding behaves as the ALU path.
    always_comb begin
        sel_data_s = alu_result;
        case (wb_sel)
            WB_SEL_ALU: sel_data_s = alu_result;
            WB_SEL_MEM: sel_data_s = load_data_s;
            WB_SEL_PC4: sel_data_s = pc_plus4;
            default:    sel_data_s = alu_result;
        endcase
    end

    assign write_en_s = in_valid & reg_write_in & (rd_in != 5'd0);

    // Stage register: flush beats stall, stall holds everything including the retire counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_data_r   <= '0;
            rd_r           <= 5'd0;
            reg_write_r    <= 1'b0;
            wb_valid_r     <= 1'b0;
            retire_count_r <= 32'd0;
        end else if (flush) begin
            reg_write_r <= 1'b0;
            wb_valid_r  <= 1'b0;
        end else if (!stall) begin
            write_data_r <= sel_data_s;
            rd_r         <= rd_in;
            reg_write_r  <= write_en_s;
            wb_valid_r   <= in_valid;
            if (in_valid) begin
                retire_count_r <= retire_count_r + 32'd1;
            end
        end
    end

    assign write_data   = write_data_r;
    assign rd           = rd_r;
    assign reg_write    = reg_write_r;
    assign wb_valid     = wb_valid_r;
    assign retire_count = retire_count_r;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a reference model pushes expected stage contents, popped after each edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, stall, flush, reg_write_in;
    logic [31:0] alu_result, mem_rdata, pc_plus4;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel, addr_lo;
    logic [2:0]  load_funct3;
    logic [31:0] write_data, retire_count;
    logic [4:0]  rd;
    logic        reg_write, wb_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        v;
        logic [31:0] ret;
    } exp_t;

    exp_t sbq[$];

    logic [31:0] m_wd, m_ret;
    logic [4:0]  m_rd;
    logic        m_rw, m_v;

    wb_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .pc_plus4     (pc_plus4),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .wb_sel       (wb_sel),
        .load_funct3  (load_funct3),
        .addr_lo      (addr_lo),
        .write_data   (write_data),
        .rd           (rd),
        .reg_write    (reg_write),
        .wb_valid     (wb_valid),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a));
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] pc, input logic [4:0] r,
                          input logic rwi, input logic [2:0] f3, input logic [1:0] a);
        in_valid = v; wb_sel = sel; alu_result = alu; mem_rdata = mem; pc_plus4 = pc;
        rd_in = r; reg_write_in = rwi; load_funct3 = f3; addr_lo = a;
    endtask

    task automatic model_reset();
        m_wd = 32'd0; m_rd = 5'd0; m_rw = 1'b0; m_v = 1'b0; m_ret = 32'd0;
    endtask

    // One clock: update the model, push the expectation, then pop and compare after the edge.
    task automatic step(input string tag);
        exp_t e;
        logic [31:0] sel;
        case (wb_sel)
            2'b01:   sel = ref_load(mem_rdata, load_funct3, addr_lo);
            2'b10:   sel = pc_plus4;
            default: sel = alu_result;
        endcase
        if (flush) begin
            m_v = 1'b0; m_rw = 1'b0;
        end else if (!stall) begin
            m_v = in_valid; m_rd = rd_in; m_wd = sel;
            m_rw = in_valid && reg_write_in && (rd_in != 5'd0);
            if (in_valid) m_ret = m_ret + 32'd1;
        end
        e.wd = m_wd; e.rd = m_rd; e.rw = m_rw; e.v = m_v; e.ret = m_ret;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check_val({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check_val({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, e.v});
            check_val({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, e.rw});
            check_val({tag, ".retire"}, retire_count, e.ret);
            if (e.v) begin
                check_val({tag, ".write_data"}, write_data, e.wd);
                check_val({tag, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".write_data"}, write_data, 32'd0);
        check_val({tag, ".rd"}, {27'd0, rd}, 32'd0);
        check_val({tag, ".reg_write"}, {31'd0, reg_write}, 32'd0);
        check_val({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd0);
        check_val({tag, ".retire"}, retire_count, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 3'b000, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        set_in(1'b1, 2'b00, 32'h00000025, 32'd0, 32'd0, 5'd5, 1'b1, 3'b010, 2'd0);
        step("alu");

        set_in(1'b1, 2'b01, 32'd0, 32'h80F17F01, 32'd0, 5'd10, 1'b1, 3'b000, 2'd2);
        step("lb2");
        check_val("lb2.value", write_data, 32'hFFFFFFF1);
        set_in(1'b1, 2'b01, 32'd0, 32'h80F17F01, 32'd0, 5'd11, 1'b1, 3'b100, 2'd3);
        step("lbu3");
        check_val("lbu3.value", write_data, 32'h00000080);
        set_in(1'b1, 2'b01, 32'd0, 32'h80F17F01, 32'd0, 5'd12, 1'b1, 3'b001, 2'd2);
        step("lh2");
        check_val("lh2.value", write_data, 32'hFFFF80F1);
        set_in(1'b1, 2'b01, 32'd0, 32'h80F17F01, 32'd0, 5'd13, 1'b1, 3'b101, 2'd0);
        step("lhu0");
        check_val("lhu0.value", write_data, 32'h00007F01);
        set_in(1'b1, 2'b01, 32'd0, 32'h80F17F01, 32'd0, 5'd14, 1'b1, 3'b001, 2'd3);
        step("lh3_ignores_bit0");
        set_in(1'b1, 2'b01, 32'd0, 32'h80F17F01, 32'd0, 5'd15, 1'b1, 3'b111, 2'd1);
        step("ld_other_is_lw");

        set_in(1'b1, 2'b10, 32'h55, 32'd0, 32'h00000104, 5'd0, 1'b1, 3'b010, 2'd0);
        step("x0_guard");
        check_val("x0_guard.value", write_data, 32'h00000104);

        set_in(1'b1, 2'b11, 32'h0000BEEF, 32'd0, 32'd0, 5'd1, 1'b1, 3'b010, 2'd0);
        step("sel11_alu");

        set_in(1'b1, 2'b00, 32'h00000777, 32'd0, 32'd0, 5'd7, 1'b1, 3'b010, 2'd0);
        step("cap_rd7");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 2'b10, 32'h100 + i, 32'd0, 32'h200 + i, 5'd20 + 5'(i), 1'b1, 3'b000, 2'(i));
            step("stall_hold");
            check_val("stall_hold.rd7", {27'd0, rd}, 32'd7);
        end
        flush = 1'b1;
        step("stall_flush");
        stall = 1'b0; flush = 1'b0;

        set_in(1'b1, 2'b00, 32'h00000A0A, 32'd0, 32'd0, 5'd9, 1'b1, 3'b010, 2'd0);
        step("pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        set_in(1'b1, 2'b00, 32'h00000033, 32'd0, 32'd0, 5'd3, 1'b1, 3'b010, 2'd0);
        step("post_reset");

        force dut.retire_count_r = 32'hFFFFFFFF;
        #1;
        release dut.retire_count_r;
        m_ret = 32'hFFFFFFFF;
        set_in(1'b1, 2'b00, 32'h00000044, 32'd0, 32'd0, 5'd4, 1'b1, 3'b010, 2'd0);
        step("wrap");
        check_val("wrap.zero", retire_count, 32'd0);

        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(7) == 0);
            set_in(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                   1'($urandom), 3'($urandom), 2'($urandom));
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
